// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: FSM state encodings and ALU
// operation codes.
package alu_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    EXEC = ST_EXEC,
    RESP = ST_RESP
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND, OR, ADD, SUB (both modulo 2^DATA_W) and unsigned
// set-less-than. Unknown op codes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result
);

  // Select the operation; carries and overflow are intentionally dropped.
  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, (a < b)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU. One operation is in flight at a
// time: IDLE accepts a request, EXEC registers the ALU result, RESP presents
// it to the granted requester until it is taken.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise
// requester 0 always wins a tie.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              busy,
  output logic [15:0]       ops_done
);

  state_t            state;
  logic              grant_id;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] alu_result;
  logic              prefer1;
  logic              win0;
  logic              win1;
  logic              resp_taken;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Points at the requester that wins the next tie.
  logic rr_ptr;
  assign prefer1 = rr_ptr;
`else
  assign prefer1 = 1'b0;
`endif

  // Pick the winner among the currently valid requesters.
  always_comb begin
    win1 = req1_valid && (!req0_valid || prefer1);
    win0 = req0_valid && !win1;
  end

  // Ready only in IDLE and never while reset is held.
  assign req0_ready = (state == IDLE) && !reset && win0;
  assign req1_ready = (state == IDLE) && !reset && win1;

  // Only the granted requester's resp_ready can complete the response.
  assign resp_taken = grant_id ? (resp1_valid && resp1_ready)
                               : (resp0_valid && resp0_ready);

  alu #(
    .DATA_W(DATA_W),
    .OP_W  (OP_W)
  ) u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .result(alu_result)
  );

  // Main FSM with registered outputs; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant_id    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      resp_data   <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      busy        <= 1'b0;
      ops_done    <= 16'd0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      rr_ptr      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win0 || win1) begin
            a_q      <= win1 ? req1_a  : req0_a;
            b_q      <= win1 ? req1_b  : req0_b;
            op_q     <= win1 ? req1_op : req0_op;
            grant_id <= win1;
            busy     <= 1'b1;
            state    <= EXEC;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            // The requester just granted drops to lowest priority.
            rr_ptr   <= !win1;
`endif
          end
        end
        EXEC: begin
          resp_data <= alu_result;
          state     <= RESP;
        end
        RESP: begin
          if (!resp0_valid && !resp1_valid) begin
            // First RESP cycle: raise the valid for the granted id only.
            resp0_valid <= !grant_id;
            resp1_valid <= grant_id;
          end else if (resp_taken) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            busy        <= 1'b0;
            ops_done    <= ops_done + 16'd1;
            state       <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have parameter OP_W, default 4, operation-code width matching the ALU control encoding.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have ports req0_valid/req1_valid, input, 1, requester N presents an operation.
REQ-006 SHALL have ports req0_ready/req1_ready, output, 1, arbiter accepts requester N this cycle.
REQ-007 SHALL have ports req0_a/req1_a and req0_b/req1_b, input, DATA_W, operands.
REQ-008 SHALL have ports req0_op/req1_op, input, OP_W: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (unsigned), others give 0.
REQ-009 SHALL have ports resp0_valid/resp1_valid, output, 1, result available for requester N.
REQ-010 SHALL have ports resp0_ready/resp1_ready, input, 1, requester N takes its result.
REQ-011 SHALL have port resp_data, output, DATA_W, registered result, shared by both response channels.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port ops_done, output, 16, count of completed response handshakes.

Function
REQ-014 SHALL implement the FSM IDLE -> EXEC -> RESP -> IDLE, with exactly one operation in flight.
REQ-015 SHALL, in IDLE, assert reqN_ready for the arbitration winner only; at most one ready is high, and ready is never high outside IDLE.
REQ-016 SHALL arbitrate as follows: if one requester is valid, that requester wins; if both are valid, the winner is per REQ-030.
REQ-017 SHALL, on reqN_valid and reqN_ready, latch operands, op and grant id, then go to EXEC.
REQ-018 SHALL, in EXEC, register the ALU output into resp_data, then go to RESP; ALU latency is exactly one cycle.
REQ-019 SHALL, in RESP, hold respN_valid high for the granted id only, with resp_data stable, until respN_ready; then go to IDLE.
REQ-020 SHALL give this timing for an accept at edge T: respN_valid is high after edge T+2, and the earliest next accept is the edge after the response handshake.
REQ-021 SHALL ignore a valid deassertion in EXEC or RESP; captured operands are unaffected by later input changes.
REQ-022 SHALL ignore resp_ready from the non-granted requester.
REQ-023 SHALL increment ops_done on each response handshake, wrapping from 0xFFFF to 0x0000.
REQ-024 SHALL compute ADD/SUB modulo 2^32 with no carry or overflow output; SLT yields 32'h1 or 32'h0.

Reset
REQ-025 SHALL, while reset is high, force state to IDLE and all of the following to 0: resp_data, ops_done, grant id, RR pointer, both resp_valid, both req_ready, busy.
REQ-026 SHALL discard any in-flight operation on reset asserted mid-operation; no response is produced for it.
REQ-027 SHALL let the first arbitration after reset favor requester 0.

Configuration
REQ-028 SHALL use macro ALU_ARB_ROUND_ROBIN_EN to select the arbitration scheme.
REQ-029 SHALL, without the macro, use fixed priority: requester 0 always wins a tie.
REQ-030 SHALL, with the macro defined, use round-robin: a 1-bit pointer is updated on each accept so that the last-granted requester has lowest priority on the next tie.

Structure
REQ-031 SHALL place state encodings (IDLE=2'b00, EXEC=2'b01, RESP=2'b10) and the ALU op codes as localparams in a shared package file alu_pkg.
REQ-032 SHALL instantiate the existing alu module as its only sub-module, driven from the latched operand/op registers.

Verification
REQ-033 SHALL include a single-request test: req0 ADD 5+7 -> resp0_valid two cycles after accept, resp_data=12, ops_done=1.
REQ-034 SHALL include a tie test: both valid, SUB 10-3 and AND F0&3C, repeated twice. Round-robin build: grants go 0,1,0,1. Fixed build: grants go 0,0; req1 is starved while req0 stays valid.
REQ-035 SHALL include a backpressure test: resp1_ready low for 5 cycles -> resp1_valid and resp_data stay stable, both req_ready stay 0, busy=1.
REQ-036 SHALL include a boundary-ops test: ADD FFFFFFFF+1 -> 0; SLT 1<2 -> 1; SLT FFFFFFFF<0 -> 0; op 4'b1111 -> 0.
REQ-037 SHALL include a mid-op reset test: assert reset in EXEC -> next cycle all outputs are 0 and state is IDLE, with no response.
REQ-038 SHALL include a counter-wrap test: preload 0xFFFF via force, complete one op -> ops_done=0.
